// File: rtl/recv_pkg.sv
// recv_pkg: shared state/status types and octet constants for the receive frame sequencer
package recv_pkg;
  typedef enum logic [2:0] {IDLE, GAP, ARMED, FRAME, ABORT} state_t;
  typedef enum logic [2:0] {
    STAT_NONE  = 3'd0,
    STAT_OK    = 3'd1,
    STAT_ERR   = 3'd2,
    STAT_DROP  = 3'd3,
    STAT_ABORT = 3'd4
  } status_t;
  localparam logic [7:0] PreambleOctet = 8'hAA;
  localparam logic [7:0] ErrorOctet    = 8'hF9;
  localparam logic [7:0] SuccessOctet  = 8'h00;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that wins over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = clr ? '0 : (inc && !(&q_q)) ? q_q + W'(1) : q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/recv_frame_ctrl.sv
// recv_frame_ctrl: arms recv_top after an inter-frame gap, classifies frames and keeps status counters
module recv_frame_ctrl
  import recv_pkg::*;
#(
  parameter int IFG_CYCLES       = 12,
  parameter int MAX_FRAME_CYCLES = 1600,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr_cnt,
  input  logic [7:0]       phy_data,
  input  logic             phy_vld,
  output logic [7:0]       rx_data,
  output logic             rx_start,
  output logic             rx_rst,
  input  logic             rx_rdy,
  input  logic             rx_vld,
  input  logic [7:0]       rx_out,
  output logic             busy,
  output logic             irq_done,
  output logic [2:0]       last_status,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic [CNT_W-1:0] frame_drop_cnt,
  output logic [CNT_W-1:0] frame_abort_cnt
);
  localparam int GW = $clog2(IFG_CYCLES + 1);
  localparam int WW = $clog2(MAX_FRAME_CYCLES + 1);
  localparam logic [GW-1:0] GapLast = GW'(IFG_CYCLES - 1);
  localparam logic [WW-1:0] WdLast  = WW'(MAX_FRAME_CYCLES - 1);
  state_t        state_q, state_d;
  status_t       status_q, status_d, cls;
  logic [GW-1:0] gap_q, gap_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          prev_vld_q, prev_vld_d, rx_rst_q, rx_rst_d, irq_q, irq_d;
  logic [7:0]    prev_out_q, prev_out_d;
  logic          wd_hit, classify;
  assign rx_data  = phy_vld ? phy_data : 8'h00;
  assign rx_start = state_q == ARMED && phy_vld && phy_data == PreambleOctet && rx_rdy && enable;
  assign wd_hit   = wd_q == WdLast;
  assign classify = state_q == FRAME && !wd_hit && rx_rdy;
  assign cls      = !prev_vld_q ? STAT_DROP : prev_out_q == SuccessOctet ? STAT_OK : STAT_ERR;
  always_comb begin
    state_d    = state_q;
    gap_d      = '0;
    wd_d       = '0;
    prev_vld_d = prev_vld_q;
    prev_out_d = prev_out_q;
    irq_d      = 1'b0;
    status_d   = status_q;
    case (state_q)
      IDLE:  state_d = enable ? GAP : IDLE;
      GAP: begin
        gap_d   = phy_vld ? '0 : gap_q + GW'(1);
        state_d = !enable ? IDLE : (!phy_vld && gap_q == GapLast) ? ARMED : GAP;
      end
      ARMED: state_d = !enable ? IDLE : rx_start ? FRAME : phy_vld ? GAP : ARMED;
      FRAME: begin
        prev_vld_d = rx_vld;
        prev_out_d = rx_out;
        wd_d       = wd_q + WW'(1);
        state_d    = wd_hit ? ABORT : classify ? (enable ? GAP : IDLE) : FRAME;
        irq_d      = classify;
        status_d   = classify ? cls : status_q;
      end
      ABORT: begin
        state_d  = GAP;
        irq_d    = 1'b1;
        status_d = STAT_ABORT;
      end
      default: state_d = IDLE;
    endcase
    rx_rst_d = state_d == ABORT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      wd_q       <= '0;
      prev_vld_q <= 1'b0;
      prev_out_q <= 8'h00;
      rx_rst_q   <= 1'b1;
      irq_q      <= 1'b0;
      status_q   <= STAT_NONE;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      wd_q       <= wd_d;
      prev_vld_q <= prev_vld_d;
      prev_out_q <= prev_out_d;
      rx_rst_q   <= rx_rst_d;
      irq_q      <= irq_d;
      status_q   <= status_d;
    end
  assign rx_rst      = rx_rst_q;
  assign busy        = state_q == FRAME || state_q == ABORT;
  assign irq_done    = irq_q;
  assign last_status = status_q;
  sat_counter #(.W(CNT_W)) u_ok    (.clk(clk), .rst_n(rst_n), .inc(classify && cls == STAT_OK),   .clr(clr_cnt), .q(frame_ok_cnt));
  sat_counter #(.W(CNT_W)) u_err   (.clk(clk), .rst_n(rst_n), .inc(classify && cls == STAT_ERR),  .clr(clr_cnt), .q(frame_err_cnt));
  sat_counter #(.W(CNT_W)) u_drop  (.clk(clk), .rst_n(rst_n), .inc(classify && cls == STAT_DROP), .clr(clr_cnt), .q(frame_drop_cnt));
  sat_counter #(.W(CNT_W)) u_abort (.clk(clk), .rst_n(rst_n), .inc(state_q == ABORT),            .clr(clr_cnt), .q(frame_abort_cnt));
endmodule

// File: tb/tb_recv_frame_ctrl.sv
// tb_recv_frame_ctrl: directed table-driven bench for the receive frame sequencer
module tb_recv_frame_ctrl;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;
  logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clr_cnt = 1'b0;
  logic          phy_vld = 1'b0, rx_rdy = 1'b0, rx_vld = 1'b0;
  logic [7:0]    phy_data = 8'h00, rx_out = 8'h00, rx_data;
  logic          rx_start, rx_rst, busy, irq_done;
  logic [2:0]    last_status;
  logic [CW-1:0] ok_cnt, err_cnt, drop_cnt, abort_cnt;
  int            checks = 0, errors = 0;
  int            e_ok = 0, e_err = 0, e_drop = 0, e_abort = 0;
  typedef struct {
    logic       v;
    logic [7:0] o;
    logic [2:0] st;
  } vec_t;
  vec_t tbl[4];
  always #5 clk = ~clk;
  recv_frame_ctrl #(.IFG_CYCLES(12), .MAX_FRAME_CYCLES(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_cnt(clr_cnt),
    .phy_data(phy_data), .phy_vld(phy_vld), .rx_data(rx_data), .rx_start(rx_start),
    .rx_rst(rx_rst), .rx_rdy(rx_rdy), .rx_vld(rx_vld), .rx_out(rx_out),
    .busy(busy), .irq_done(irq_done), .last_status(last_status),
    .frame_ok_cnt(ok_cnt), .frame_err_cnt(err_cnt),
    .frame_drop_cnt(drop_cnt), .frame_abort_cnt(abort_cnt)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    phy_vld = 1'b0;
    repeat (n) cyc();
  endtask
  function automatic int bump(input int c);
    return c == SAT ? SAT : c + 1;
  endfunction
  task automatic chk_cnt(input string nm);
    chk({nm, " ok_cnt"}, 32'(ok_cnt), e_ok);
    chk({nm, " err_cnt"}, 32'(err_cnt), e_err);
    chk({nm, " drop_cnt"}, 32'(drop_cnt), e_drop);
    chk({nm, " abort_cnt"}, 32'(abort_cnt), e_abort);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, " rx_rst"}, 32'(rx_rst), 1);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " irq"}, 32'(irq_done), 0);
    chk({nm, " status"}, 32'(last_status), 0);
    chk({nm, " rx_start"}, 32'(rx_start), 0);
    e_ok = 0; e_err = 0; e_drop = 0; e_abort = 0;
    chk_cnt(nm);
  endtask
  task automatic frame(input logic v, input logic [7:0] o, input logic [2:0] st,
                       input logic clr, input string nm);
    phy_vld = 1'b1; phy_data = 8'hAA; rx_rdy = 1'b1;
    #1;
    chk({nm, " rx_start"}, 32'(rx_start), 1);
    chk({nm, " rx_data"}, 32'(rx_data), 32'hAA);
    cyc();
    chk({nm, " busy"}, 32'(busy), 1);
    phy_data = 8'h55; rx_rdy = 1'b0;
    #1;
    chk({nm, " rx_start in frame"}, 32'(rx_start), 0);
    repeat (3) cyc();
    rx_vld = v; rx_out = o;
    cyc();
    rx_vld = 1'b0; rx_out = 8'h00; rx_rdy = 1'b1; phy_vld = 1'b0; clr_cnt = clr;
    chk({nm, " irq before"}, 32'(irq_done), 0);
    cyc();
    clr_cnt = 1'b0;
    if (clr) begin
      e_ok = 0; e_err = 0; e_drop = 0; e_abort = 0;
    end else if (st == 3'd1) e_ok = bump(e_ok);
    else if (st == 3'd2) e_err = bump(e_err);
    else if (st == 3'd3) e_drop = bump(e_drop);
    chk({nm, " irq"}, 32'(irq_done), 1);
    chk({nm, " status"}, 32'(last_status), 32'(st));
    chk({nm, " busy after"}, 32'(busy), 0);
    chk_cnt(nm);
    cyc();
    chk({nm, " irq one cycle"}, 32'(irq_done), 0);
  endtask
  initial begin
    tbl[0] = '{1'b1, 8'h00, 3'd1};
    tbl[1] = '{1'b1, 8'hF9, 3'd2};
    tbl[2] = '{1'b0, 8'h00, 3'd3};
    tbl[3] = '{1'b1, 8'h55, 3'd2};
    phy_data = 8'h33;
    #12;
    chk_reset("reset");
    chk("rx_data idle", 32'(rx_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    chk("rx_rst release", 32'(rx_rst), 0);
    enable = 1'b1;
    cyc();
    idle(12);
    for (int i = 0; i < 4; i++) begin
      frame(tbl[i].v, tbl[i].o, tbl[i].st, 1'b0, $sformatf("vec%0d", i));
      idle(11);
    end
    frame(1'b1, 8'h00, 3'd1, 1'b0, "ok2");
    idle(4);
    phy_vld = 1'b1; phy_data = 8'hAA; rx_rdy = 1'b1;
    #1;
    chk("short gap rx_start", 32'(rx_start), 0);
    repeat (10) cyc();
    chk("short gap busy", 32'(busy), 0);
    idle(12);
    frame(1'b1, 8'h00, 3'd1, 1'b0, "after gap");
    idle(11);
    frame(1'b1, 8'h00, 3'd1, 1'b0, "saturate");
    idle(11);
    phy_vld = 1'b1; phy_data = 8'hAA; rx_rdy = 1'b1;
    #1;
    chk("wd rx_start", 32'(rx_start), 1);
    cyc();
    phy_data = 8'h55; rx_rdy = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (i == 20) phy_vld = 1'b0;
      cyc();
    end
    chk("wd rx_rst before", 32'(rx_rst), 0);
    chk("wd busy", 32'(busy), 1);
    cyc();
    chk("wd rx_rst", 32'(rx_rst), 1);
    chk("wd abort busy", 32'(busy), 1);
    chk("wd abort irq early", 32'(irq_done), 0);
    cyc();
    e_abort = bump(e_abort);
    chk("wd rx_rst one cycle", 32'(rx_rst), 0);
    chk("wd irq", 32'(irq_done), 1);
    chk("wd status", 32'(last_status), 4);
    chk("wd busy after", 32'(busy), 0);
    chk_cnt("wd");
    rx_rdy = 1'b1;
    idle(12);
    frame(1'b1, 8'h00, 3'd1, 1'b1, "clr with class");
    idle(11);
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("clr keeps status", 32'(last_status), 1);
    enable = 1'b0; phy_vld = 1'b1; phy_data = 8'hAA; rx_rdy = 1'b1;
    #1;
    chk("disable armed rx_start", 32'(rx_start), 0);
    cyc();
    chk("disable idle rx_start", 32'(rx_start), 0);
    chk("disable idle busy", 32'(busy), 0);
    cyc();
    chk("disable still idle", 32'(rx_start), 0);
    phy_vld = 1'b0; enable = 1'b1;
    cyc();
    idle(12);
    frame(1'b1, 8'h00, 3'd1, 1'b0, "reenabled");
    idle(11);
    phy_vld = 1'b1; phy_data = 8'hAA; rx_rdy = 1'b1;
    cyc();
    phy_data = 8'h55; rx_rdy = 1'b0; rx_vld = 1'b1; rx_out = 8'h00;
    repeat (3) cyc();
    chk("midframe busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset("midframe reset");
    phy_vld = 1'b0; rx_vld = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rx_rst release 2", 32'(rx_rst), 0);
    chk_cnt("after reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
